vga_timing_ctrl: RTL and testbench

Parametrised VGA timing and pixel-alignment controller. It succeeds the fixed 640x480 display interface with compile-time resolution and porch settings, sync polarity, colour depth and upstream pixel-fetch latency. It adds a run/stop control that only stops on a frame boundary, plus start-of-frame and frame-count outputs. It sits between the pixel source (frame buffer, ROM or pattern generator) and the VGA pins, in the pixel-clock domain after the reset synchroniser.

---
 rtl/vga_timing_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator with run/stop on frame boundaries and a flag pipeline
// that lines sync/blanking up with pixel data returned by a latent source.
module vga_timing_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int COLOR_BITS  = 4,
    parameter int PIX_LATENCY = 2,
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int X_W        = $clog2(H_TOTAL),
    localparam int Y_W        = $clog2(V_TOTAL)
) (
    input  logic                    i_clk25m,
    input  logic                    i_rstn_clk25m,
    input  logic                    i_en,
    input  logic [3*COLOR_BITS-1:0] i_pixel_data,
    output logic [X_W-1:0]          o_VGA_x,
    output logic [Y_W-1:0]          o_VGA_y,
    output logic [COLOR_BITS-1:0]   o_VGA_red,
    output logic [COLOR_BITS-1:0]   o_VGA_green,
    output logic [COLOR_BITS-1:0]   o_VGA_blue,
    output logic                    o_VGA_hsync,
    output logic                    o_VGA_vsync,
    output logic                    o_VGA_video,
    output logic                    o_sof,
    output logic [15:0]             o_frame_cnt
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [X_W-1:0] H_LAST    = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_LAST    = Y_W'(V_TOTAL - 1);
    // One extra bit so window ends equal to the total still fit.
    localparam logic [X_W:0]   H_ACT_END = (X_W+1)'(H_ACTIVE);
    localparam logic [X_W:0]   HS_BEG    = (X_W+1)'(H_ACTIVE + H_FP);
    localparam logic [X_W:0]   HS_END    = (X_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W:0]   V_ACT_END = (Y_W+1)'(V_ACTIVE);
    localparam logic [Y_W:0]   VS_BEG    = (Y_W+1)'(V_ACTIVE + V_FP);
    localparam logic [Y_W:0]   VS_END    = (Y_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    state_t         state_reg, state_next;
    logic [X_W-1:0] h_reg, h_next;
    logic [Y_W-1:0] v_reg, v_next;
    logic [15:0]    frame_cnt_reg, frame_cnt_next;

    logic           line_end;
    logic           frame_end;
    assign line_end  = (h_reg == H_LAST);
    assign frame_end = line_end && (v_reg == V_LAST);

    always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
        if (!i_rstn_clk25m) begin
            state_reg     <= ST_IDLE;
            h_reg         <= '0;
            v_reg         <= '0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            h_reg         <= h_next;
            v_reg         <= v_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        h_next         = h_reg;
        v_next         = v_reg;
        frame_cnt_next = frame_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                h_next = '0;
                v_next = '0;
                if (i_en) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (frame_end) begin
                    h_next         = '0;
                    v_next         = '0;
                    frame_cnt_next = frame_cnt_reg + 16'd1;
                    // Stop is only honoured here so a frame is never cut short.
                    if (!i_en) begin
                        state_next = ST_IDLE;
                    end
                end else if (line_end) begin
                    h_next = '0;
                    v_next = v_reg + 1'b1;
                end else begin
                    h_next = h_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    logic           running;
    logic [X_W:0]   h_ext;
    logic [Y_W:0]   v_ext;
    logic [3:0]     raw_flags;
    logic [3:0]     dly_flags;

    assign running = (state_reg == ST_RUN);
    assign h_ext   = {1'b0, h_reg};
    assign v_ext   = {1'b0, v_reg};

    // Flag order: {sof, vsync_active, hsync_active, video}
    assign raw_flags[0] = running && (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    assign raw_flags[1] = running && (h_ext >= HS_BEG) && (h_ext < HS_END);
    assign raw_flags[2] = running && (v_ext >= VS_BEG) && (v_ext < VS_END);
    assign raw_flags[3] = running && (h_reg == '0) && (v_reg == '0);

    genvar gi;
    generate
        for (gi = 0; gi < PIX_LATENCY; gi++) begin : g_dly
            logic [3:0] stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
                    if (!i_rstn_clk25m) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= raw_flags;
                    end
                end
            end else begin : g_chain
                always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
                    if (!i_rstn_clk25m) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= g_dly[gi-1].stage_reg;
                    end
                end
            end
        end
        if (PIX_LATENCY == 0) begin : g_nodly
            assign dly_flags = raw_flags;
        end else begin : g_tap
            assign dly_flags = g_dly[PIX_LATENCY-1].stage_reg;
        end
    endgenerate

    logic [3*COLOR_BITS-1:0] color_reg;
    logic                    hsync_reg;
    logic                    vsync_reg;
    logic                    video_reg;
    logic                    sof_reg;

    always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
        if (!i_rstn_clk25m) begin
            color_reg <= '0;
            hsync_reg <= ~HSYNC_POL;
            vsync_reg <= ~VSYNC_POL;
            video_reg <= 1'b0;
            sof_reg   <= 1'b0;
        end else begin
            color_reg <= dly_flags[0] ? i_pixel_data : '0;
            hsync_reg <= dly_flags[1] ? HSYNC_POL : ~HSYNC_POL;
            vsync_reg <= dly_flags[2] ? VSYNC_POL : ~VSYNC_POL;
            video_reg <= dly_flags[0];
            sof_reg   <= dly_flags[3];
        end
    end

    assign o_VGA_x     = h_reg;
    assign o_VGA_y     = v_reg;
    assign o_VGA_red   = color_reg[3*COLOR_BITS-1 -: COLOR_BITS];
    assign o_VGA_green = color_reg[2*COLOR_BITS-1 -: COLOR_BITS];
    assign o_VGA_blue  = color_reg[COLOR_BITS-1 -: COLOR_BITS];
    assign o_VGA_hsync = hsync_reg;
    assign o_VGA_vsync = vsync_reg;
    assign o_VGA_video = video_reg;
    assign o_sof       = sof_reg;
    assign o_frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a reduced raster: a frame-position reference
// model plus a latency-2 pixel source derived from the DUT's coordinates.
module tb_vga_timing_ctrl;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 2;
    localparam int VA = 6,  VFP = 1, VS = 2, VBP = 1;
    localparam int CB = 4, LAT = 2;
    localparam bit HPOL = 1'b0, VPOL = 1'b0;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [11:0] pix_data = '0;
    logic [4:0]  vx;
    logic [3:0]  vy;
    logic [3:0]  vr, vg, vb;
    logic        hsync, vsync, video, sof;
    logic [15:0] fc;

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
        .COLOR_BITS(CB), .PIX_LATENCY(LAT)
    ) dut (
        .i_clk25m(clk), .i_rstn_clk25m(rst_n), .i_en(en), .i_pixel_data(pix_data),
        .o_VGA_x(vx), .o_VGA_y(vy),
        .o_VGA_red(vr), .o_VGA_green(vg), .o_VGA_blue(vb),
        .o_VGA_hsync(hsync), .o_VGA_vsync(vsync), .o_VGA_video(video),
        .o_sof(sof), .o_frame_cnt(fc)
    );

    typedef struct { bit run; int h; int v; } ent_t;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [11:0] key;
    bit          m_run;
    int          m_pos;
    int          m_frames;
    ent_t        hq[$];
    int          d0x, d0y, d1x, d1y, d2x, d2y;
    int          e_x, e_y;
    logic [11:0] e_col;
    logic        e_hs, e_vs, e_vid, e_sof;
    logic [15:0] e_fc;

    function automatic logic [11:0] pix_f(int x, int y);
        logic [7:0] xb = x[7:0];
        logic [7:0] yb = y[7:0];
        return {xb[3:0], yb[3:0], xb[7:4]} ^ key;
    endfunction

    function automatic logic [40:0] obs_vec();
        return {vx, vy, vr, vg, vb, hsync, vsync, video, sof, fc};
    endfunction

    function automatic logic [40:0] exp_vec();
        return {5'(e_x), 4'(e_y), e_col, e_hs, e_vs, e_vid, e_sof, e_fc};
    endfunction

    task automatic model_reset();
        ent_t idle;
        idle.run = 1'b0; idle.h = 0; idle.v = 0;
        m_run = 1'b0; m_pos = 0; m_frames = 0;
        hq.delete();
        for (int i = 0; i < LAT + 1; i++) hq.push_back(idle);
        e_x = 0; e_y = 0; e_col = '0; e_fc = '0;
        e_hs = ~HPOL; e_vs = ~VPOL; e_vid = 1'b0; e_sof = 1'b0;
    endtask

    // One clock: advance the model by the run/stop rules, then present pixel data.
    task automatic tick();
        bit   en_s, vid, hs, vs;
        ent_t eo, ne;
        @(posedge clk);
        en_s = en;
        eo = hq[0];
        hq.delete(0);
        if (!m_run) begin
            if (en_s) begin m_run = 1'b1; m_pos = 0; end
        end else begin
            m_pos++;
            if (m_pos == FRAME) begin
                m_pos = 0;
                m_frames = (m_frames + 1) % 65536;
                if (!en_s) m_run = 1'b0;
            end
        end
        ne.run = m_run;
        ne.h = m_run ? m_pos % HT : 0;
        ne.v = m_run ? m_pos / HT : 0;
        hq.push_back(ne);
        e_x = ne.h; e_y = ne.v; e_fc = 16'(m_frames);
        vid = eo.run && eo.h < HA && eo.v < VA;
        hs  = eo.run && eo.h >= HA + HFP && eo.h < HA + HFP + HS;
        vs  = eo.run && eo.v >= VA + VFP && eo.v < VA + VFP + VS;
        e_vid = vid;
        e_sof = eo.run && eo.h == 0 && eo.v == 0;
        e_hs  = hs ? HPOL : ~HPOL;
        e_vs  = vs ? VPOL : ~VPOL;
        e_col = vid ? pix_f(eo.h, eo.v) : 12'h000;
        #1;
        d2x = d1x; d2y = d1y;
        d1x = d0x; d1y = d0y;
        d0x = int'(vx); d0y = int'(vy);
        pix_data = pix_f(d2x, d2y);
    endtask

    task automatic wait_xy(input int tx, input int ty, output bit found);
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (int'(vx) == tx && int'(vy) == ty) begin found = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (hsync !== ~HPOL) $display("FAIL rst_hsync: got %b expected %b", hsync, ~HPOL); else n_pass++;
        n_checks++; if (vsync !== ~VPOL) $display("FAIL rst_vsync: got %b expected %b", vsync, ~VPOL); else n_pass++;
        n_checks++; if ({vr, vg, vb} !== 12'h000) $display("FAIL rst_colour: got %h expected 000", {vr, vg, vb}); else n_pass++;
        n_checks++; if ({video, sof} !== 2'b00) $display("FAIL rst_video_sof: got %b expected 00", {video, sof}); else n_pass++;
        n_checks++; if ({vx, vy} !== 9'd0) $display("FAIL rst_xy: got %h expected 0", {vx, vy}); else n_pass++;
        n_checks++; if (fc !== 16'd0) $display("FAIL rst_frame_cnt: got %h expected 0", fc); else n_pass++;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL idle_after_reset: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_start_and_lines();
        int n, last_fall, lo_len, per, vid_cnt;
        logic prev_hs;
        repeat ($urandom_range(5, 0)) tick();
        en = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n = i;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL start_cycle: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
            if (sof === 1'b1) break;
        end
        // Ticks counted include the edge that samples en, so the pulse lands on tick LAT+2.
        n_checks++; if (n !== LAT + 2 || sof !== 1'b1) $display("FAIL first_sof_latency: got %0d expected %0d", n, LAT + 2); else n_pass++;
        last_fall = -1; lo_len = -1; per = -1; vid_cnt = 0; prev_hs = hsync;
        for (int t = 0; t < FRAME; t++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL line_cycle x=%0d y=%0d: got %h expected %h", e_x, e_y, obs_vec(), exp_vec());
            else n_pass++;
            if (video === 1'b1) vid_cnt++;
            if (prev_hs === 1'b1 && hsync === 1'b0) begin
                if (last_fall >= 0 && per < 0) per = t - last_fall;
                last_fall = t;
            end
            if (prev_hs === 1'b0 && hsync === 1'b1 && last_fall >= 0 && lo_len < 0) lo_len = t - last_fall;
            prev_hs = hsync;
        end
        n_checks++; if (lo_len !== HS) $display("FAIL hsync_width: got %0d expected %0d", lo_len, HS); else n_pass++;
        n_checks++; if (per !== HT) $display("FAIL hsync_period: got %0d expected %0d", per, HT); else n_pass++;
        n_checks++; if (vid_cnt !== HA * VA) $display("FAIL video_per_frame: got %0d expected %0d", vid_cnt, HA * VA); else n_pass++;
    endtask

    task automatic test_vertical();
        int sof_t0, sof_t1, vs_fall, vs_len;
        logic [15:0] fc_at0, fc_at1;
        logic prev_vs;
        sof_t0 = -1; sof_t1 = -1; vs_fall = -1; vs_len = -1; prev_vs = vsync;
        fc_at0 = '0; fc_at1 = '0;
        for (int t = 0; t < 2 * FRAME; t++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL vert_cycle x=%0d y=%0d: got %h expected %h", e_x, e_y, obs_vec(), exp_vec());
            else n_pass++;
            if (sof === 1'b1) begin
                if (sof_t0 < 0) begin sof_t0 = t; fc_at0 = fc; end
                else if (sof_t1 < 0) begin sof_t1 = t; fc_at1 = fc; end
            end
            if (prev_vs === 1'b1 && vsync === 1'b0 && vs_fall < 0) vs_fall = t;
            if (prev_vs === 1'b0 && vsync === 1'b1 && vs_fall >= 0 && vs_len < 0) vs_len = t - vs_fall;
            prev_vs = vsync;
        end
        n_checks++; if (sof_t1 - sof_t0 !== FRAME) $display("FAIL sof_spacing: got %0d expected %0d", sof_t1 - sof_t0, FRAME); else n_pass++;
        n_checks++; if (vs_len !== VS * HT) $display("FAIL vsync_width: got %0d expected %0d", vs_len, VS * HT); else n_pass++;
        n_checks++; if (fc_at1 !== fc_at0 + 16'd1) $display("FAIL frame_cnt_step: got %0d expected %0d", fc_at1, fc_at0 + 16'd1); else n_pass++;
    endtask

    task automatic test_alignment();
        int blank_bad;
        blank_bad = 0;
        for (int t = 0; t < FRAME; t++) begin
            tick();
            n_checks++;
            if ({vr, vg, vb} !== e_col) $display("FAIL pixel_align x=%0d y=%0d: got %h expected %h", e_x, e_y, {vr, vg, vb}, e_col);
            else n_pass++;
            if (video !== 1'b1 && {vr, vg, vb} !== 12'h000) blank_bad++;
        end
        n_checks++; if (blank_bad !== 0) $display("FAIL blank_colour: got %0d nonzero cycles expected 0", blank_bad); else n_pass++;
    endtask

    task automatic test_en_glitch();
        bit found;
        int sof_cnt;
        wait_xy($urandom_range(HT - 1, 0), $urandom_range(VT - 3, 0), found);
        n_checks++; if (!found) $display("FAIL glitch_wait: got timeout expected coordinate"); else n_pass++;
        en = 1'b0;
        repeat ($urandom_range(HT, 1)) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL glitch_low_cycle: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
        end
        en = 1'b1;
        sof_cnt = 0;
        for (int t = 0; t < 2 * FRAME; t++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL glitch_cycle: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
            if (sof === 1'b1) sof_cnt++;
        end
        n_checks++; if (sof_cnt !== 2) $display("FAIL glitch_sof_count: got %0d expected 2", sof_cnt); else n_pass++;
    endtask

    task automatic test_graceful_stop();
        bit found;
        int wrap_t;
        logic [15:0] fc0;
        wait_xy($urandom_range(HT - 1, 0), $urandom_range(VT - 1, 0), found);
        n_checks++; if (!found) $display("FAIL stop_wait: got timeout expected coordinate"); else n_pass++;
        fc0 = fc;
        en = 1'b0;
        wrap_t = -1;
        for (int t = 1; t <= FRAME + 40; t++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL stop_cycle: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
            if (wrap_t < 0 && fc !== fc0) wrap_t = t;
            if (wrap_t >= 0) begin
                n_checks++; if ({vx, vy, sof} !== 10'd0) $display("FAIL stop_xy_sof: got %h expected 0", {vx, vy, sof}); else n_pass++;
                if (t >= wrap_t + LAT + 1) begin
                    n_checks++;
                    if ({hsync, vsync, video} !== {~HPOL, ~VPOL, 1'b0})
                        $display("FAIL stop_idle_syncs: got %b expected %b", {hsync, vsync, video}, {~HPOL, ~VPOL, 1'b0});
                    else n_pass++;
                end
            end
        end
        n_checks++; if (wrap_t < 0) $display("FAIL stop_wrap_seen: got none expected one wrap"); else n_pass++;
        n_checks++; if (fc !== fc0 + 16'd1) $display("FAIL stop_frame_cnt: got %0d expected %0d", fc, fc0 + 16'd1); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit found;
        int n;
        en = 1'b1;
        repeat (3) tick();
        wait_xy($urandom_range(HT - 2, 1), $urandom_range(VT - 1, 0), found);
        n_checks++; if (!found) $display("FAIL areset_wait: got timeout expected coordinate"); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({vx, vy, vr, vg, vb, hsync, vsync, video, sof, fc} !== {9'd0, 12'h000, ~HPOL, ~VPOL, 2'b00, 16'd0})
            $display("FAIL areset_outputs: got %h expected %h", {vx, vy, vr, vg, vb, hsync, vsync, video, sof, fc},
                     {9'd0, 12'h000, ~HPOL, ~VPOL, 2'b00, 16'd0});
        else n_pass++;
        model_reset();
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL areset_idle: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
        end
        en = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n = i;
            if (sof === 1'b1) break;
        end
        n_checks++; if (n !== LAT + 2 || sof !== 1'b1) $display("FAIL areset_first_sof: got %0d expected %0d", n, LAT + 2); else n_pass++;
        for (int t = 0; t < FRAME; t++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL areset_run_cycle: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        key = 12'($urandom);
        d0x = 0; d0y = 0; d1x = 0; d1y = 0; d2x = 0; d2y = 0;
        model_reset();
        test_reset();
        test_start_and_lines();
        test_vertical();
        test_alignment();
        test_en_glitch();
        test_graceful_stop();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
